xmem_cfg_issuer: RTL and testbench
==================================

// Module: xmem_cfg_issuer
// PURPOSE
// - Initiator side of the xmem configuration path. Takes config records (cmd, index, data, repeat) from the
//   boot/host sequencer and serialises them into single-word writes on the RISC-style config bus.
// - Writes land in the xmem config window (address bit XMEM_CFG_ABIT set) and are decoded by the xmem config decoder.
// - Sits between the host CSR/boot ROM sequencer and the xmem config decoder. One write per granted beat.
// PARAMETERS
// - XMEM_CFG_ABIT  19  address bit selecting the config window
// - CMD_W          6   command field width; cmd occupies m_addr[CMD_W+IDX_W-1:IDX_W]
// - IDX_W          12  index field width (bank/part/range index); occupies m_addr[IDX_W-1:0]
// - CMD_NUM        40  legal commands 0..CMD_NUM-1 (CMD_SET_SBANK..CMD_CYCLIC_SUB_PART_DEPTH)
// - DW             32  data width (RISC_DWIDTH)
// - CNT_W          8   repeat-count width
// PORTS
// - clk          in   1      clock; all logic on rising edge
// - rst          in   1      synchronous reset, active-high
// - s_valid      in   1      record valid
// - s_ready      out  1      record accepted when s_valid&&s_ready
// - s_cmd        in   CMD_W  config command code
// - s_idx        in   IDX_W  start index
// - s_data       in   DW     write data of first beat
// - s_cnt        in   CNT_W  beats in record; 0 treated as 1
// - s_data_inc   in   1      1: data +1 per beat; 0: constant data
// - m_req        out  1      bus write request
// - m_we         out  1      1 = write, 0 = read (read only with readback)
// - m_addr       out  32     (1<<XMEM_CFG_ABIT) | cmd<<IDX_W | idx
// - m_wdata      out  DW     write data
// - m_gnt        in   1      request accepted this cycle when m_req&&m_gnt
// - m_rvalid     in   1      read data valid (readback only)
// - m_rdata      in   DW     read data (readback only)
// - busy         out  1      record in progress
// - err          out  1      sticky error flag
// - err_code     out  2      0 none, 1 illegal cmd, 2 readback mismatch
// - err_clr      in   1      clears err/err_code next cycle
// - wr_cnt       out  16     total granted writes since reset, wraps at 2^16
// BEHAVIOUR
// - Reset: state IDLE; s_ready=1; m_req=0; m_we=0; m_addr=0; m_wdata=0; busy=0; err=0; err_code=0; wr_cnt=0.
// - States: IDLE -> ISSUE -> (RB_REQ -> RB_WAIT ->) ISSUE | IDLE.
// - IDLE: s_ready=1. On accept, latch record; beats = (s_cnt==0) ? 1 : s_cnt.
//   Legal cmd: m_req=1, m_we=1, ISSUE the next cycle (latency 1). s_cmd>=CMD_NUM: no bus activity;
//   err=1, err_code=1 next cycle; stay IDLE.
// - ISSUE: m_req held high; m_addr, m_wdata, m_we held stable until m_gnt. On grant:
//   wr_cnt+1; idx+1 (wraps mod 2^IDX_W, cmd field untouched); data+1 if s_data_inc (wraps mod 2^DW); beats-1.
//   Last beat granted: m_req=0, IDLE next cycle. Otherwise the next beat is presented the following cycle.
//   Back-to-back grants give 1 write/cycle.
// - s_ready=0 and busy=1 in every non-IDLE state. A new record is accepted the cycle after return to IDLE.
// - err_clr has priority over a same-cycle new error. A new error while err=1 does not overwrite err_code
//   (first error kept).
// - Reset mid-record: record dropped. Outputs take reset values the cycle after rst is sampled high.
// - Reset does not wait for a pending grant or rvalid; the bus side must tolerate the abandoned request.
// CONFIGURATION
// - XMEM_CFG_READBACK_EN defined: after each granted write, go to RB_REQ.
//   RB_REQ: m_req=1, m_we=0, same m_addr. On grant go to RB_WAIT.
//   RB_WAIT: wait for m_rvalid. If m_rdata != written data: err=1, err_code=2. Record continues either way.
//   Then go to ISSUE for the next beat, or IDLE after the last beat. wr_cnt counts writes only.
// - XMEM_CFG_READBACK_EN undefined: no RB states; m_we always 1 while m_req=1; m_rvalid/m_rdata ignored.
// TESTING
// - Single record: cmd=3, idx=5, data=0xA5, cnt=1, m_gnt tied 1
//   -> one write addr=0x0008_3005, wdata=0xA5; wr_cnt=1; s_ready high 2 cycles after accept.
// - Burst: cmd=9, idx=0xFFE, data=10, cnt=4, data_inc=1
//   -> idx 0xFFE,0xFFF,0x000,0x001, data 10..13; cmd field stays 9; 4 consecutive writes.
// - Stall: m_gnt low 5 cycles -> m_req, m_addr, m_wdata stable for all 5 cycles; exactly one write on grant.
// - Illegal cmd=40 -> no m_req; err=1, err_code=1; err_clr -> err=0 the next cycle; next legal record proceeds.
// - Reset mid-burst: rst after beat 2 of cnt=8 -> m_req=0, busy=0, wr_cnt=0 the next cycle; no further writes.
// - Readback (XMEM_CFG_READBACK_EN): m_rdata = wdata^1 on beat 1 -> err_code=2; remaining beats still issued.

Source files
------------

// File: rtl/xmem_cfg_issuer.sv
// xmem_cfg_issuer: serialises config records (cmd, idx, data, repeat) into
// single-word writes on the config bus, inside the xmem config window.
// Optional feature macro: XMEM_CFG_READBACK_EN (read back and compare each write).
module xmem_cfg_issuer #(
  parameter int unsigned XMEM_CFG_ABIT = 19,
  parameter int unsigned CMD_W         = 6,
  parameter int unsigned IDX_W         = 12,
  parameter int unsigned CMD_NUM       = 40,
  parameter int unsigned DW            = 32,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [CMD_W-1:0] s_cmd,
  input  logic [IDX_W-1:0] s_idx,
  input  logic [DW-1:0]    s_data,
  input  logic [CNT_W-1:0] s_cnt,
  input  logic             s_data_inc,
  output logic             m_req,
  output logic             m_we,
  output logic [31:0]      m_addr,
  output logic [DW-1:0]    m_wdata,
  input  logic             m_gnt,
  input  logic             m_rvalid,
  input  logic [DW-1:0]    m_rdata,
  output logic             busy,
  output logic             err,
  output logic [1:0]       err_code,
  input  logic             err_clr,
  output logic [15:0]      wr_cnt
);

  localparam int unsigned AW     = 32;
  localparam int unsigned WCNT_W = 16;
  localparam int unsigned ERR_W  = 2;

  localparam logic [ERR_W-1:0] ERR_NONE = ERR_W'(0);
  localparam logic [ERR_W-1:0] ERR_CMD  = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_RB   = ERR_W'(2);

  localparam logic [AW-1:0] WIN_BIT = AW'(1) << XMEM_CFG_ABIT;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RB_REQ  = 2'd2,
    ST_RB_WAIT = 2'd3
  } state_e;

  state_e             state_q;
  logic               s_ready_q;
  logic               m_req_q;
  logic               m_we_q;
  logic [AW-1:0]      m_addr_q;
  logic [DW-1:0]      m_wdata_q;
  logic               busy_q;
  logic [CNT_W-1:0]   beats_q;
  logic               inc_q;
  logic [WCNT_W-1:0]  wr_cnt_q;
  logic               err_q;
  logic [ERR_W-1:0]   err_code_q;

  logic               accept;
  logic               cmd_legal;
  logic [AW-1:0]      first_addr;
  logic [CNT_W-1:0]   first_beats;
  logic [AW-1:0]      addr_nxt;
  logic [DW-1:0]      data_nxt;
  logic               last_beat;
  logic               new_err;
  logic [ERR_W-1:0]   new_code;

  assign accept      = (state_q == ST_IDLE) && s_valid && s_ready_q;
  assign cmd_legal   = (32'(s_cmd) < CMD_NUM);
  assign first_addr  = WIN_BIT | (AW'(s_cmd) << IDX_W) | AW'(s_idx);
  assign first_beats = (s_cnt == '0) ? CNT_W'(1) : s_cnt;
  // Index field wraps on its own; the cmd field and window bit are untouched.
  assign addr_nxt    = {m_addr_q[AW-1:IDX_W], m_addr_q[IDX_W-1:0] + IDX_W'(1)};
  assign data_nxt    = inc_q ? (m_wdata_q + DW'(1)) : m_wdata_q;
  assign last_beat   = (beats_q == CNT_W'(1));

`ifdef XMEM_CFG_READBACK_EN
  logic rb_mismatch;
  assign rb_mismatch = (state_q == ST_RB_WAIT) && m_rvalid && (m_rdata != m_wdata_q);
`else
  logic unused_rb;
  assign unused_rb = ^{m_rvalid, m_rdata};
`endif

  // Error source selection: illegal command on accept, or readback mismatch.
  always_comb begin
    new_err  = 1'b0;
    new_code = ERR_NONE;
    if (accept && !cmd_legal) begin
      new_err  = 1'b1;
      new_code = ERR_CMD;
    end
`ifdef XMEM_CFG_READBACK_EN
    else if (rb_mismatch) begin
      new_err  = 1'b1;
      new_code = ERR_RB;
    end
`endif
  end

  // Record sequencer: accept, issue beats, optionally read back each write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      s_ready_q <= 1'b1;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      busy_q    <= 1'b0;
      beats_q   <= '0;
      inc_q     <= 1'b0;
      wr_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && cmd_legal) begin
            m_addr_q  <= first_addr;
            m_wdata_q <= s_data;
            beats_q   <= first_beats;
            inc_q     <= s_data_inc;
            m_req_q   <= 1'b1;
            m_we_q    <= 1'b1;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (m_gnt) begin
            wr_cnt_q <= wr_cnt_q + WCNT_W'(1);
`ifdef XMEM_CFG_READBACK_EN
            // Same address, now as a read; advance happens after the compare.
            m_we_q  <= 1'b0;
            state_q <= ST_RB_REQ;
`else
            m_addr_q  <= addr_nxt;
            m_wdata_q <= data_nxt;
            beats_q   <= beats_q - CNT_W'(1);
            if (last_beat) begin
              m_req_q   <= 1'b0;
              m_we_q    <= 1'b0;
              s_ready_q <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= ST_IDLE;
            end
`endif
          end
        end
`ifdef XMEM_CFG_READBACK_EN
        ST_RB_REQ: begin
          if (m_gnt) begin
            m_req_q <= 1'b0;
            state_q <= ST_RB_WAIT;
          end
        end
        ST_RB_WAIT: begin
          if (m_rvalid) begin
            m_addr_q  <= addr_nxt;
            m_wdata_q <= data_nxt;
            beats_q   <= beats_q - CNT_W'(1);
            if (last_beat) begin
              s_ready_q <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= ST_IDLE;
            end else begin
              m_req_q <= 1'b1;
              m_we_q  <= 1'b1;
              state_q <= ST_ISSUE;
            end
          end
        end
`endif
        default: begin
          m_req_q   <= 1'b0;
          m_we_q    <= 1'b0;
          s_ready_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky error flag: clear wins over a new error; first error code is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else if (err_clr) begin
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else if (new_err && !err_q) begin
      err_q      <= 1'b1;
      err_code_q <= new_code;
    end
  end

  assign s_ready  = s_ready_q;
  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_xmem_cfg_issuer.sv
// Scoreboard bench for xmem_cfg_issuer: expected writes are queued by the
// stimulus, a negedge monitor pops and compares every granted write.
module tb_xmem_cfg_issuer;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [5:0]  s_cmd;
  logic [11:0] s_idx;
  logic [31:0] s_data;
  logic [7:0]  s_cnt;
  logic        s_data_inc;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_gnt;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        busy;
  logic        err;
  logic [1:0]  err_code;
  logic        err_clr;
  logic [15:0] wr_cnt;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  wr_seen = 0;
  bit  corrupt_next = 1'b0;

  xmem_cfg_issuer dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_cmd(s_cmd), .s_idx(s_idx),
    .s_data(s_data), .s_cnt(s_cnt), .s_data_inc(s_data_inc),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy), .err(err), .err_code(err_code), .err_clr(err_clr),
    .wr_cnt(wr_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void push(logic [31:0] addr, logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endfunction

  // Monitor: a write handshake seen at negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!rst && m_req && m_gnt && m_we) begin
      wr_t e;
      wr_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected none", m_addr, m_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", m_addr, e.addr);
        chk("wr_data", m_wdata, e.data);
      end
    end
  end

`ifdef XMEM_CFG_READBACK_EN
  // Read responder: returns the written word one cycle after the read grant.
  initial begin
    logic [31:0] rb;
    forever begin
      @(negedge clk);
      if (!rst && m_req && m_gnt && !m_we) begin
        rb = m_wdata ^ (corrupt_next ? 32'h1 : 32'h0);
        corrupt_next = 1'b0;
        @(posedge clk); #1;
        m_rvalid = 1'b1;
        m_rdata  = rb;
        @(posedge clk); #1;
        m_rvalid = 1'b0;
      end
    end
  end
`endif

  task automatic send(input logic [5:0] cmd, input logic [11:0] idx,
                      input logic [31:0] data, input logic [7:0] cnt, input logic inc);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b1; s_cmd = cmd; s_idx = idx; s_data = data; s_cnt = cnt; s_data_inc = inc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: got s_ready 0 expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy 1 expected 0 within 500 cycles");
    end
  endtask

  initial begin
    int base;
    bit ok;
    rst = 1'b1; s_valid = 1'b0; s_cmd = '0; s_idx = '0; s_data = '0; s_cnt = '0;
    s_data_inc = 1'b0; m_gnt = 1'b1; m_rvalid = 1'b0; m_rdata = '0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);

    // Single record
    push(32'h0008_3005, 32'h0000_00A5);
    send(6'd3, 12'd5, 32'hA5, 8'd1, 1'b0);
`ifndef XMEM_CFG_READBACK_EN
    @(negedge clk);
    chk("single_req_c1", 32'(m_req), 32'd1);
    chk("single_ready_c1", 32'(s_ready), 32'd0);
    chk("single_busy_c1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("single_req_c2", 32'(m_req), 32'd0);
    chk("single_ready_c2", 32'(s_ready), 32'd1);
`endif
    wait_idle();
    chk("single_wr_cnt", 32'(wr_cnt), 32'd1);

    // Burst across the index wrap, data incrementing
    push(32'h0008_9FFE, 32'd10);
    push(32'h0008_9FFF, 32'd11);
    push(32'h0008_9000, 32'd12);
    push(32'h0008_9001, 32'd13);
    send(6'd9, 12'hFFE, 32'd10, 8'd4, 1'b1);
`ifndef XMEM_CFG_READBACK_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("burst_req_held", 32'(m_req), 32'd1);
    end
    @(negedge clk);
    chk("burst_req_done", 32'(m_req), 32'd0);
`endif
    wait_idle();
    chk("burst_wr_cnt", 32'(wr_cnt), 32'd5);

    // Stall: grant withheld 5 cycles
    m_gnt = 1'b0;
    push(32'h0008_1010, 32'h0000_1234);
    send(6'd1, 12'h010, 32'h1234, 8'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_req", 32'(m_req), 32'd1);
      chk("stall_addr", m_addr, 32'h0008_1010);
      chk("stall_data", m_wdata, 32'h0000_1234);
    end
    @(posedge clk); #1 m_gnt = 1'b1;
    wait_idle();
    chk("stall_wr_cnt", 32'(wr_cnt), 32'd6);

    // Illegal command: no bus activity, sticky error
    send(6'd40, 12'd0, 32'd0, 8'd1, 1'b0);
    @(negedge clk);
    chk("ill_req", 32'(m_req), 32'd0);
    chk("ill_busy", 32'(busy), 32'd0);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_code", 32'(err_code), 32'd1);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_code", 32'(err_code), 32'd0);

    // err_clr wins over a same-cycle illegal command
    err_clr = 1'b1;
    send(6'd63, 12'd0, 32'd0, 8'd1, 1'b0);
    err_clr = 1'b0;
    @(negedge clk);
    chk("clr_prio_err", 32'(err), 32'd0);

    // Highest legal command, cnt=0 treated as one beat
    push(32'h000A_7ABC, 32'hFFFF_FFFF);
    send(6'd39, 12'hABC, 32'hFFFF_FFFF, 8'd0, 1'b1);
    wait_idle();
    chk("last_cmd_wr_cnt", 32'(wr_cnt), 32'd7);
    chk("last_cmd_err", 32'(err), 32'd0);

    // Reset after beat 2 of an 8-beat record
    push(32'h0008_5000, 32'h0000_0100);
    push(32'h0008_5001, 32'h0000_0101);
    base = wr_seen;
    send(6'd5, 12'd0, 32'h100, 8'd8, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (wr_seen == base + 2) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL midrst_wait: got %0d writes expected 2", wr_seen - base);
    end
    rst = 1'b1; m_gnt = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_req", 32'(m_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("midrst_ready", 32'(s_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0; m_gnt = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_more", 32'(wr_seen - base), 32'd2);

`ifdef XMEM_CFG_READBACK_EN
    // Readback mismatch on beat 1; remaining beats still issued
    corrupt_next = 1'b1;
    push(32'h0008_2000, 32'h50);
    push(32'h0008_2001, 32'h51);
    push(32'h0008_2002, 32'h52);
    send(6'd2, 12'd0, 32'h50, 8'd3, 1'b1);
    wait_idle();
    chk("rb_err", 32'(err), 32'd1);
    chk("rb_code", 32'(err_code), 32'd2);
    chk("rb_wr_cnt", 32'(wr_cnt), 32'd3);
`endif

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
